// File: rtl/pmu_event_serializer.sv
// Per-source saturating event buffers drained round-robin onto a single event-ID stream.
// Latency: 2 cycles from event_i to e_id_o. There is no backpressure: events beyond the counter saturate and set ovf_o.
module pmu_event_serializer #(
  parameter int NUM_SRC    = 8,
  parameter int EID_WIDTH  = 8,
  parameter int PEND_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NUM_SRC-1:0]   event_i,
  input  logic                 clr_i,
  output logic [EID_WIDTH-1:0] e_id_o,
  output logic                 e_valid_o,
  output logic [NUM_SRC-1:0]   ovf_o,
  output logic                 busy_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW    = IDX_W + 1;
  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] CNT_ONE = PEND_WIDTH'(1);
  localparam logic [IDX_W-1:0]      PTR_RST = IDX_W'(NUM_SRC - 1);
  localparam logic [CW-1:0]         CAND_N  = CW'(NUM_SRC);

  logic [PEND_WIDTH-1:0] r_cnt [NUM_SRC];
  logic [NUM_SRC-1:0]    r_ovf;
  logic [IDX_W-1:0]      r_ptr;
  logic [EID_WIDTH-1:0]  r_e_id;
  logic                  r_e_valid;

  logic [NUM_SRC-1:0]    w_nz;
  logic [NUM_SRC-1:0]    w_inc;
  logic [NUM_SRC-1:0]    w_dec;
  logic                  w_gnt_vld;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [CW-1:0]         w_cand;
  logic [EID_WIDTH-1:0]  w_eid;

  always_comb begin
    w_nz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_nz[i] = (r_cnt[i] != '0);
    end
  end

  assign w_inc = event_i & {NUM_SRC{en_i}};

  // Cyclic search starting just after the last winner; a clear suppresses the grant.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = {1'b0, r_ptr} + CW'(k);
      if (w_cand >= CAND_N) begin
        w_cand = w_cand - CAND_N;
      end
      if (!w_gnt_vld && !clr_i && w_nz[w_cand[IDX_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_dec = '0;
    if (w_gnt_vld) begin
      w_dec[w_gnt_idx] = 1'b1;
    end
  end

  assign w_eid = EID_WIDTH'(w_gnt_idx) + EID_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_ONE;
          end
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr     <= PTR_RST;
      r_e_id    <= '0;
      r_e_valid <= 1'b0;
    end else begin
      r_e_valid <= w_gnt_vld;
      r_e_id    <= w_gnt_vld ? w_eid : '0;
      if (w_gnt_vld) begin
        r_ptr <= w_gnt_idx;
      end
    end
  end

  assign e_id_o    = r_e_id;
  assign e_valid_o = r_e_valid;
  assign ovf_o     = r_ovf;
  assign busy_o    = |w_nz;

endmodule
